// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file writeback writer.
// Holds the widths and the writeback request bundle.
package rf_wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // True when a request would actually change architectural state.
  function automatic logic writes_reg(input wb_req_t r);
    return r.rd != '0;
  endfunction

endpackage

// File: rtl/rf_wb_lq_fifo.sv
// Load-result queue for the writeback writer.
// Entries are also exposed oldest-first for the bypass search.
module rf_wb_lq_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_req_t                push_req,
  input  logic                   pop,
  output wb_req_t                head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output wb_req_t [DEPTH-1:0]    ord_req,
  output logic [DEPTH-1:0]       ord_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  wb_req_t       mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap by width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage; stale slots are masked by ord_valid, so no reset.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_req;
  end

  // Present entries ordered from head (oldest) to tail (youngest).
  always_comb begin
    ord_req   = '0;
    ord_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ord_req[i]   = mem[rd_ptr + PW'(i)];
      ord_valid[i] = (CW'(i) < cnt);
    end
  end

endmodule

// File: rtl/rf_wb_writer.sv
// Writeback writer: merges ALU and load results onto WE3/A3/WD3.
// Loads wait in a queue; decode can bypass pending writes.
module rf_wb_writer #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LQ_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [ADDR_W-1:0]         alu_rd,
  input  logic [DATA_W-1:0]         alu_data,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [ADDR_W-1:0]         ld_rd,
  input  logic [DATA_W-1:0]         ld_data,
  output logic                      WE3,
  output logic [ADDR_W-1:0]         A3,
  output logic [DATA_W-1:0]         WD3,
  input  logic [ADDR_W-1:0]         byp_a1,
  input  logic [ADDR_W-1:0]         byp_a2,
  output logic                      byp_hit1,
  output logic                      byp_hit2,
  output logic [DATA_W-1:0]         byp_d1,
  output logic [DATA_W-1:0]         byp_d2,
  output logic [$clog2(LQ_DEPTH):0] lq_count
);

  import rf_wb_pkg::wb_req_t;
  import rf_wb_pkg::writes_reg;

  wb_req_t                 alu_req;
  wb_req_t                 ld_req;
  wb_req_t                 lq_head;
  wb_req_t                 issue_req;
  wb_req_t [LQ_DEPTH-1:0]  lq_ord;
  logic    [LQ_DEPTH-1:0]  lq_vld;
  logic                    lq_full;
  logic                    lq_empty;
  logic                    alu_fire;
  logic                    ld_fire;
  logic                    lq_pop;
  logic                    issue_valid;

  assign alu_req.rd   = alu_rd;
  assign alu_req.data = alu_data;
  assign ld_req.rd    = ld_rd;
  assign ld_req.data  = ld_data;

  // Readies come from registered occupancy only, so no
  // valid-to-ready loop; a full queue stalls the ALU and
  // lets the head drain first.
  assign ld_ready  = !rst && !lq_full;
  assign alu_ready = !rst && !lq_full;

  assign alu_fire = alu_valid && alu_ready;
  assign ld_fire  = ld_valid && ld_ready;

  // ALU owns the write slot when it fires; otherwise drain.
  assign lq_pop      = !alu_fire && !lq_empty;
  assign issue_valid = alu_fire || lq_pop;
  assign issue_req   = alu_fire ? alu_req : lq_head;

  rf_wb_lq_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk       (clk),
    .rst       (rst),
    .push      (ld_fire),
    .push_req  (ld_req),
    .pop       (lq_pop),
    .head      (lq_head),
    .full      (lq_full),
    .empty     (lq_empty),
    .count     (lq_count),
    .ord_req   (lq_ord),
    .ord_valid (lq_vld)
  );

  // Output stage; x0 results move A3/WD3 but never assert WE3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WE3 <= 1'b0;
      A3  <= '0;
      WD3 <= '0;
    end else begin
      WE3 <= issue_valid && writes_reg(issue_req);
      if (issue_valid) begin
        A3  <= issue_req.rd;
        WD3 <= issue_req.data;
      end
    end
  end

  logic [ADDR_W-1:0] q_addr [2];
  logic              q_hit  [2];
  logic [DATA_W-1:0] q_data [2];

  assign q_addr[0] = byp_a1;
  assign q_addr[1] = byp_a2;
  assign byp_hit1  = q_hit[0];
  assign byp_hit2  = q_hit[1];
  assign byp_d1    = q_data[0];
  assign byp_d2    = q_data[1];

  // Bypass search: output stage is oldest, then queue head to
  // tail, so the last match found is the youngest write.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      q_hit[p]  = 1'b0;
      q_data[p] = '0;
      if (WE3 && (A3 == q_addr[p])) begin
        q_hit[p]  = 1'b1;
        q_data[p] = WD3;
      end
      for (int i = 0; i < LQ_DEPTH; i++) begin
        if (lq_vld[i] && (lq_ord[i].rd == q_addr[p])) begin
          q_hit[p]  = 1'b1;
          q_data[p] = lq_ord[i].data;
        end
      end
      if (q_addr[p] == '0) begin
        q_hit[p]  = 1'b0;
        q_data[p] = '0;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_writer.sv
// Directed bench for rf_wb_writer.
// Expected values are hand-derived per step.
module tb_rf_wb_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [4:0]  byp_a1;
  logic [4:0]  byp_a2;
  logic        byp_hit1;
  logic        byp_hit2;
  logic [31:0] byp_d1;
  logic [31:0] byp_d2;
  logic [1:0]  lq_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_wb_writer #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .LQ_DEPTH (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .WE3       (WE3),
    .A3        (A3),
    .WD3       (WD3),
    .byp_a1    (byp_a1),
    .byp_a2    (byp_a2),
    .byp_hit1  (byp_hit1),
    .byp_hit2  (byp_hit2),
    .byp_d1    (byp_d1),
    .byp_d2    (byp_d2),
    .lq_count  (lq_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input string tag, input logic we,
                    input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we"}, 64'(WE3), 64'(we));
    chk({tag, ".a3"}, 64'(A3), 64'(a));
    chk({tag, ".wd"}, 64'(WD3), 64'(d));
  endtask

  task automatic alu(input logic v, input logic [4:0] r,
                     input logic [31:0] d);
    alu_valid = v;
    alu_rd    = r;
    alu_data  = d;
  endtask

  task automatic ld(input logic v, input logic [4:0] r,
                    input logic [31:0] d);
    ld_valid = v;
    ld_rd    = r;
    ld_data  = d;
  endtask

  initial begin
    rst = 1'b1;
    alu(0, 0, 0);
    ld(0, 0, 0);
    byp_a1 = 0;
    byp_a2 = 0;
    #12;
    wr("reset", 0, 0, 0);
    chk("reset.cnt", 64'(lq_count), 0);
    chk("reset.alu_rdy", 64'(alu_ready), 0);
    chk("reset.ld_rdy", 64'(ld_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // 1: single ALU write
    alu(1, 5, 32'hDEADBEEF);
    #1 chk("t1.alu_rdy", 64'(alu_ready), 1);
    step();
    alu(0, 0, 0);
    wr("t1.c1", 1, 5, 32'hDEADBEEF);
    step();
    chk("t1.c2.we", 64'(WE3), 0);

    // 2: load queued behind ALU
    alu(1, 3, 32'h22);
    ld(1, 7, 32'h11);
    #1 chk("t2.cnt0", 64'(lq_count), 0);
    step();
    alu(0, 0, 0);
    ld(0, 0, 0);
    wr("t2.c1", 1, 3, 32'h22);
    chk("t2.cnt1", 64'(lq_count), 1);
    step();
    wr("t2.c2", 1, 7, 32'h11);
    chk("t2.cnt2", 64'(lq_count), 0);
    step();
    chk("t2.c3.we", 64'(WE3), 0);

    // 3: fill queue, then head beats a waiting ALU result
    alu(1, 10, 32'hA0);
    ld(1, 8, 32'h80);
    step();
    alu(1, 11, 32'hB0);
    ld(1, 9, 32'h90);
    chk("t3.cnt1", 64'(lq_count), 1);
    step();
    alu(1, 12, 32'hC0);
    ld(0, 0, 0);
    #1;
    chk("t3.cnt2", 64'(lq_count), 2);
    chk("t3.full.alu_rdy", 64'(alu_ready), 0);
    chk("t3.full.ld_rdy", 64'(ld_ready), 0);
    wr("t3.alu11", 1, 11, 32'hB0);
    step();
    wr("t3.pop8", 1, 8, 32'h80);
    chk("t3.cnt3", 64'(lq_count), 1);
    chk("t3.alu_rdy_back", 64'(alu_ready), 1);
    step();
    alu(0, 0, 0);
    wr("t3.alu12", 1, 12, 32'hC0);
    step();
    wr("t3.pop9", 1, 9, 32'h90);
    chk("t3.cnt4", 64'(lq_count), 0);
    step();

    // 4: x0 result completes but never writes
    alu(1, 0, 32'hFFFF);
    byp_a1 = 0;
    #1 chk("t4.alu_rdy", 64'(alu_ready), 1);
    step();
    alu(0, 0, 0);
    wr("t4.x0", 0, 0, 32'hFFFF);
    chk("t4.hit1", 64'(byp_hit1), 0);
    step();

    // 5: bypass picks youngest pending write
    alu(1, 20, 32'h200);
    ld(1, 4, 32'hA);
    step();
    alu(1, 21, 32'h210);
    ld(1, 4, 32'hB);
    step();
    alu(0, 0, 0);
    ld(0, 0, 0);
    byp_a1 = 4;
    byp_a2 = 21;
    #1;
    chk("t5.cnt", 64'(lq_count), 2);
    chk("t5.q.hit1", 64'(byp_hit1), 1);
    chk("t5.q.d1", 64'(byp_d1), 32'hB);
    chk("t5.os.hit2", 64'(byp_hit2), 1);
    chk("t5.os.d2", 64'(byp_d2), 32'h210);
    step();
    wr("t5.popA", 1, 4, 32'hA);
    chk("t5.mix.d1", 64'(byp_d1), 32'hB);
    chk("t5.miss.hit2", 64'(byp_hit2), 0);
    step();
    wr("t5.popB", 1, 4, 32'hB);
    chk("t5.os.hit1", 64'(byp_hit1), 1);
    chk("t5.os.d1", 64'(byp_d1), 32'hB);
    step();
    chk("t5.clr.hit1", 64'(byp_hit1), 0);
    chk("t5.clr.d1", 64'(byp_d1), 0);
    byp_a1 = 0;
    byp_a2 = 0;

    // 6: asynchronous reset with work in flight
    alu(1, 22, 32'h22);
    ld(1, 23, 32'h33);
    step();
    alu(1, 24, 32'h24);
    ld(1, 25, 32'h35);
    step();
    alu(0, 0, 0);
    ld(0, 0, 0);
    chk("t6.pre.cnt", 64'(lq_count), 2);
    wr("t6.pre", 1, 24, 32'h24);
    #2 rst = 1'b1;
    #1;
    wr("t6.async", 0, 0, 0);
    chk("t6.async.cnt", 64'(lq_count), 0);
    chk("t6.async.rdy", 64'(alu_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6.post.we", 64'(WE3), 0);
      chk("t6.post.cnt", 64'(lq_count), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
